board_state_controller: RTL and testbench

//  Tic-tac-toe game-state engine; sits directly upstream of the VGA controller and drives its CONTROL_ARRAY.

---
 rtl/board_state_controller_if.sv | 24 ++
 rtl/board_state_controller.sv | 205 ++++++++++++++++++++
 tb/tb_board_state_controller.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/board_state_controller_if.sv
// Button pulses in, display codes and game status out, between the
// board-state engine (slave) and its surroundings (master).
interface board_state_controller_if;
  logic        BTN_UP;
  logic        BTN_DOWN;
  logic        BTN_LEFT;
  logic        BTN_RIGHT;
  logic        BTN_SELECT;
  logic [35:0] CONTROL_ARRAY;
  logic        CUR_PLAYER;
  logic [3:0]  MOVE_COUNT;
  logic        GAME_OVER;
  logic [1:0]  WINNER;

  modport master (
    output BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_SELECT,
    input  CONTROL_ARRAY, CUR_PLAYER, MOVE_COUNT, GAME_OVER, WINNER
  );

  modport slave (
    input  BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_SELECT,
    output CONTROL_ARRAY, CUR_PLAYER, MOVE_COUNT, GAME_OVER, WINNER
  );
endinterface

// File: rtl/board_state_controller.sv
// Tic-tac-toe game-state engine driving the VGA stage CONTROL_ARRAY.
// Define CURSOR_BLINK_EN to blink the cursor flag every BLINK_PERIOD clocks.
module board_state_controller #(
  parameter int CELL_W       = 4,
  parameter bit START_PLAYER = 1'b0,
  parameter int BLINK_PERIOD = 25_000_000
) (
  input logic                     CLK,
  input logic                     RESET,
  board_state_controller_if.slave bus
);

  typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;

  localparam logic [1:0] CROSS = 2'b00;
  localparam logic [1:0] ZERO  = 2'b01;
  localparam logic [1:0] EMPTY = 2'b10;
  localparam logic [9*CELL_W-1:0] RESET_CTRL = 36'h2222A2222;

  // The display stage hard-codes a 4-bit cell code.
  if (CELL_W != 4 || BLINK_PERIOD < 1) begin : g_cfg_check
    $error("board_state_controller: CELL_W must be 4 and BLINK_PERIOD >= 1");
  end

  state_t               state_q, state_d;
  logic [8:0][1:0]      board_q, board_d;
  logic [8:0]           win_q, win_d;
  logic [1:0]           row_q, row_d;
  logic [1:0]           col_q, col_d;
  logic                 player_q, player_d;
  logic [3:0]           count_q, count_d;
  logic                 over_q, over_d;
  logic [1:0]           winner_q, winner_d;
  logic [9*CELL_W-1:0]  ctrl_q, ctrl_d;

  logic [3:0] cur_idx_q, cur_idx_d;
  logic [1:0] mark;
  logic [8:0] mine;
  logic       restart;
  logic       cursor_on;

`ifdef CURSOR_BLINK_EN
  localparam int BLINK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
`endif

  function automatic logic [3:0] cell_index(input logic [1:0] r, input logic [1:0] c);
    return ({2'b00, r} << 1) + {2'b00, r} + {2'b00, c};
  endfunction

  // Eight winning lines as cell masks: rows, columns, then both diagonals.
  function automatic logic [8:0] line_mask(input int k);
    case (k)
      0:       return 9'b000_000_111;
      1:       return 9'b000_111_000;
      2:       return 9'b111_000_000;
      3:       return 9'b001_001_001;
      4:       return 9'b010_010_010;
      5:       return 9'b100_100_100;
      6:       return 9'b100_010_001;
      7:       return 9'b001_010_100;
      default: return 9'b000_000_000;
    endcase
  endfunction

  assign cur_idx_q = cell_index(row_q, col_q);
  assign cur_idx_d = cell_index(row_d, col_d);

  always_comb begin
    state_d  = state_q;
    board_d  = board_q;
    win_d    = win_q;
    row_d    = row_q;
    col_d    = col_q;
    player_d = player_q;
    count_d  = count_q;
    over_d   = over_q;
    winner_d = winner_q;
    restart  = 1'b0;
    mark     = player_q ? ZERO : CROSS;
    mine     = '0;
    for (int j = 0; j < 9; j++) begin
      mine[j] = (board_q[j] == mark);
    end

    case (state_q)
      PLAY: begin
        if (bus.BTN_SELECT) begin
          if (board_q[cur_idx_q] == EMPTY) begin
            board_d[cur_idx_q] = mark;
            count_d            = count_q + 4'd1;
            state_d            = CHECK;
          end
        end else if (bus.BTN_UP) begin
          row_d = (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;
        end else if (bus.BTN_DOWN) begin
          row_d = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
        end else if (bus.BTN_LEFT) begin
          col_d = (col_q == 2'd0) ? 2'd2 : col_q - 2'd1;
        end else if (bus.BTN_RIGHT) begin
          col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        end
      end
      CHECK: begin
        for (int k = 0; k < 8; k++) begin
          if ((mine & line_mask(k)) == line_mask(k)) begin
            win_d = win_d | line_mask(k);
          end
        end
        if (win_d != 9'd0) begin
          state_d  = WIN;
          over_d   = 1'b1;
          winner_d = player_q ? 2'b10 : 2'b01;
        end else if (count_q == 4'd9) begin
          state_d  = DRAW;
          over_d   = 1'b1;
          winner_d = 2'b11;
        end else begin
          player_d = ~player_q;
          state_d  = PLAY;
        end
      end
      WIN, DRAW: begin
        restart = bus.BTN_SELECT;
      end
      default: state_d = PLAY;
    endcase

    if (restart) begin
      state_d  = PLAY;
      board_d  = {9{EMPTY}};
      win_d    = '0;
      row_d    = 2'd1;
      col_d    = 2'd1;
      player_d = START_PLAYER;
      count_d  = '0;
      over_d   = 1'b0;
      winner_d = 2'b00;
    end

`ifdef CURSOR_BLINK_EN
    // Any cursor move or restart shows the cursor immediately for a full half-period.
    if (restart || (row_d != row_q) || (col_d != col_q)) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_PERIOD - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
      blink_phase_d = blink_phase_q;
    end
    cursor_on = blink_phase_d && ((state_d == PLAY) || (state_d == CHECK));
`else
    cursor_on = (state_d == PLAY) || (state_d == CHECK);
`endif

    ctrl_d = '0;
    for (int i = 0; i < 9; i++) begin
      ctrl_d[i*CELL_W +: CELL_W] = {cursor_on && (cur_idx_d == 4'(i)), win_d[i], board_d[i]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= PLAY;
      board_q  <= {9{EMPTY}};
      win_q    <= '0;
      row_q    <= 2'd1;
      col_q    <= 2'd1;
      player_q <= START_PLAYER;
      count_q  <= '0;
      over_q   <= 1'b0;
      winner_q <= 2'b00;
      ctrl_q   <= RESET_CTRL;
`ifdef CURSOR_BLINK_EN
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      board_q  <= board_d;
      win_q    <= win_d;
      row_q    <= row_d;
      col_q    <= col_d;
      player_q <= player_d;
      count_q  <= count_d;
      over_q   <= over_d;
      winner_q <= winner_d;
      ctrl_q   <= ctrl_d;
`ifdef CURSOR_BLINK_EN
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
`endif
    end
  end

  assign bus.CONTROL_ARRAY = ctrl_q;
  assign bus.CUR_PLAYER    = player_q;
  assign bus.MOVE_COUNT    = count_q;
  assign bus.GAME_OVER     = over_q;
  assign bus.WINNER        = winner_q;

endmodule

// File: tb/tb_board_state_controller.sv
// Directed bench for board_state_controller: vector table for cursor and
// placement basics, hand-written sequences for win, draw and reset corners.
module tb_board_state_controller;

  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_SEL   = 5'b10000;
  localparam logic [4:0] B_UP    = 5'b01000;
  localparam logic [4:0] B_DOWN  = 5'b00100;
  localparam logic [4:0] B_LEFT  = 5'b00010;
  localparam logic [4:0] B_RIGHT = 5'b00001;

  typedef struct {
    string       name;
    logic [4:0]  btn;
    logic [35:0] ctrl;
    logic        player;
    logic [3:0]  count;
    logic        over;
    logic [1:0]  winner;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cur_row;
  int   cur_col;
  vec_t vecs[15];

  always #5 clk = ~clk;

  board_state_controller_if bus ();

  board_state_controller dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // Called at a falling edge; holds the pulse across one rising edge.
  task automatic applyStimulus(input logic [4:0] btn);
    {bus.BTN_SELECT, bus.BTN_UP, bus.BTN_DOWN, bus.BTN_LEFT, bus.BTN_RIGHT} = btn;
    @(posedge clk);
    @(negedge clk);
    {bus.BTN_SELECT, bus.BTN_UP, bus.BTN_DOWN, bus.BTN_LEFT, bus.BTN_RIGHT} = B_NONE;
  endtask

  task automatic checkOutput(input string name, input logic [35:0] ctrl, input logic player,
                             input logic [3:0] count, input logic over, input logic [1:0] winner);
    checks++;
    if (bus.CONTROL_ARRAY !== ctrl || bus.CUR_PLAYER !== player || bus.MOVE_COUNT !== count ||
        bus.GAME_OVER !== over || bus.WINNER !== winner) begin
      errors++;
      $display("[TB] FAIL %s: got ctrl=%h player=%b count=%0d over=%b winner=%b, expected ctrl=%h player=%b count=%0d over=%b winner=%b",
               name, bus.CONTROL_ARRAY, bus.CUR_PLAYER, bus.MOVE_COUNT, bus.GAME_OVER, bus.WINNER,
               ctrl, player, count, over, winner);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cur_row = 1;
    cur_col = 1;
  endtask

  task automatic moveTo(input int r, input int c);
    for (int i = 0; i < 3 && cur_row != r; i++) begin
      applyStimulus(B_DOWN);
      cur_row = (cur_row + 1) % 3;
    end
    for (int i = 0; i < 3 && cur_col != c; i++) begin
      applyStimulus(B_RIGHT);
      cur_col = (cur_col + 1) % 3;
    end
  endtask

  task automatic placeAt(input int r, input int c);
    moveTo(r, c);
    applyStimulus(B_SEL);
    applyStimulus(B_NONE);
  endtask

  initial begin
    rst = 1'b0;
    {bus.BTN_SELECT, bus.BTN_UP, bus.BTN_DOWN, bus.BTN_LEFT, bus.BTN_RIGHT} = B_NONE;

    vecs[0]  = '{"right_to_5",       B_RIGHT, 36'h222A22222, 1'b0, 4'd0, 1'b0, 2'b00};
    vecs[1]  = '{"right_wrap_to_3",  B_RIGHT, 36'h22222A222, 1'b0, 4'd0, 1'b0, 2'b00};
    vecs[2]  = '{"up_beats_left",    5'b01010, 36'h22222222A, 1'b0, 4'd0, 1'b0, 2'b00};
    vecs[3]  = '{"left_wrap_to_2",   B_LEFT,  36'h222222A22, 1'b0, 4'd0, 1'b0, 2'b00};
    vecs[4]  = '{"down_to_5",        B_DOWN,  36'h222A22222, 1'b0, 4'd0, 1'b0, 2'b00};
    vecs[5]  = '{"down_to_8",        B_DOWN,  36'hA22222222, 1'b0, 4'd0, 1'b0, 2'b00};
    vecs[6]  = '{"down_wrap_to_2",   B_DOWN,  36'h222222A22, 1'b0, 4'd0, 1'b0, 2'b00};
    vecs[7]  = '{"up_wrap_to_8",     B_UP,    36'hA22222222, 1'b0, 4'd0, 1'b0, 2'b00};
    vecs[8]  = '{"right_wrap_to_6",  B_RIGHT, 36'h22A222222, 1'b0, 4'd0, 1'b0, 2'b00};
    vecs[9]  = '{"all_btns_select",  5'b11111, 36'h228222222, 1'b0, 4'd1, 1'b0, 2'b00};
    vecs[10] = '{"right_in_check",   B_RIGHT, 36'h228222222, 1'b1, 4'd1, 1'b0, 2'b00};
    vecs[11] = '{"select_occupied",  B_SEL,   36'h228222222, 1'b1, 4'd1, 1'b0, 2'b00};
    vecs[12] = '{"up_to_3",          B_UP,    36'h22022A222, 1'b1, 4'd1, 1'b0, 2'b00};
    vecs[13] = '{"zero_at_3",        B_SEL,   36'h220229222, 1'b1, 4'd2, 1'b0, 2'b00};
    vecs[14] = '{"check_to_cross",   B_NONE,  36'h220229222, 1'b0, 4'd2, 1'b0, 2'b00};

    @(negedge clk);
    doReset();
    checkOutput("reset_state", 36'h2222A2222, 1'b0, 4'd0, 1'b0, 2'b00);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].btn);
      checkOutput(vecs[i].name, vecs[i].ctrl, vecs[i].player, vecs[i].count, vecs[i].over, vecs[i].winner);
    end

    // Select at the centre, then again on the same occupied cell.
    doReset();
    applyStimulus(B_SEL);
    checkOutput("centre_in_check", 36'h222282222, 1'b0, 4'd1, 1'b0, 2'b00);
    applyStimulus(B_NONE);
    checkOutput("centre_turn_pass", 36'h222282222, 1'b1, 4'd1, 1'b0, 2'b00);
    applyStimulus(B_SEL);
    checkOutput("centre_reselect", 36'h222282222, 1'b1, 4'd1, 1'b0, 2'b00);

    // Cross takes the top row.
    doReset();
    placeAt(0, 0);
    placeAt(1, 0);
    placeAt(0, 1);
    placeAt(1, 1);
    placeAt(0, 2);
    checkOutput("top_row_win", 36'h222211444, 1'b0, 4'd5, 1'b1, 2'b01);
    applyStimulus(B_UP | B_LEFT);
    checkOutput("win_ignores_dirs", 36'h222211444, 1'b0, 4'd5, 1'b1, 2'b01);
    applyStimulus(B_SEL);
    checkOutput("restart_after_win", 36'h2222A2222, 1'b0, 4'd0, 1'b0, 2'b00);

    // Full board with no line.
    doReset();
    placeAt(0, 0);
    placeAt(0, 1);
    placeAt(0, 2);
    placeAt(1, 1);
    placeAt(1, 0);
    placeAt(1, 2);
    placeAt(2, 1);
    placeAt(2, 0);
    moveTo(2, 2);
    applyStimulus(B_SEL);
    checkOutput("ninth_in_check", 36'h801110010, 1'b0, 4'd9, 1'b0, 2'b00);
    applyStimulus(B_NONE);
    checkOutput("draw", 36'h001110010, 1'b0, 4'd9, 1'b1, 2'b11);
    applyStimulus(B_SEL);
    checkOutput("restart_after_draw", 36'h2222A2222, 1'b0, 4'd0, 1'b0, 2'b00);

    // Ninth move completes row 0 and column 0 together: win, both lines flagged.
    doReset();
    placeAt(0, 1);
    placeAt(1, 1);
    placeAt(0, 2);
    placeAt(1, 2);
    placeAt(1, 0);
    placeAt(2, 1);
    placeAt(2, 0);
    placeAt(2, 2);
    placeAt(0, 0);
    checkOutput("double_line_win", 36'h114114444, 1'b0, 4'd9, 1'b1, 2'b01);

    // Reset asserted while the placed mark is being checked, with a select pending.
    doReset();
    applyStimulus(B_SEL);
    rst = 1'b1;
    applyStimulus(B_SEL);
    rst = 1'b0;
    checkOutput("reset_mid_check", 36'h2222A2222, 1'b0, 4'd0, 1'b0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
